uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Oversampling UART receiver: 1 start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- RX_IN is sampled on CLK, which runs at Prescale × the bit rate.
- Recovered byte is presented on P_DATA with a one-cycle data_valid strobe.
- Sits between the asynchronous serial pin (pre-synchronised upstream) and the byte-consuming logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
- CLK  input  1  oversampling clock, Prescale cycles per serial bit.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idle high.
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present between data and stop.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  8  last correctly received byte.
- data_valid  output  1  one-cycle strobe: P_DATA updated with a good frame.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE; all counters clear.
  - P_DATA=8'h00, data_valid=0.
- Latching: Prescale, PAR_EN and PAR_TYP are latched on start-bit detection and held for the whole frame. Changes mid-frame have no effect.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit.
  - bit_cnt counts data bits 0..7.
- Sampling:
  - Each bit is sampled at edge_cnt = P/2-1, P/2 and P/2+1, where P is the latched Prescale.
  - Bit value is the 2-of-3 majority, available at edge_cnt = P/2+2.
- IDLE:
  - RX_IN=0 seen on a CLK edge -> START, with edge_cnt=0 on that cycle.
- START:
  - If the majority sample is 1 (glitch) -> IDLE immediately; no output change.
  - Otherwise, at edge_cnt=P-1 -> DATA.
- DATA:
  - Majority sample is shifted into a shift register at bit position bit_cnt (LSB first).
  - After bit 7 completes (edge_cnt=P-1): if PAR_EN -> PARITY, else -> STOP.
- PARITY:
  - Expected bit = XOR of the 8 data bits XOR PAR_TYP.
  - A mismatch sets an internal par_err flag.
  - At edge_cnt=P-1 -> STOP.
- STOP:
  - Majority sample must be 1; otherwise an internal stp_err flag is set.
  - At edge_cnt=P-1 -> IDLE.
  - If neither par_err nor stp_err is set: P_DATA <= shift register, and data_valid=1 for exactly that one cycle.
- Error frame: P_DATA holds its old value, no strobe, FSM still returns to IDLE.
- Output hold: P_DATA holds until the next good frame; it is never cleared except by reset.
- Back-to-back frames: a start bit detected in the first IDLE cycle after STOP is accepted. Total frame length is (10 + PAR_EN) × P cycles.
- Line conditions:
  - RX_IN held low in IDLE restarts START every time it completes.
  - A line stuck high stays in IDLE.
- Reset mid-frame aborts immediately; the next frame needs a fresh falling edge.
- Prescale values other than 8/16/32 are unsupported; behaviour is undefined but must not lock up. Reset recovers.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 -> one data_valid pulse, P_DATA=0xA5 and held after the pulse.
- Prescale=16, PAR_EN=0, frame 0x3C; then Prescale=32, frame 0xF0 -> P_DATA=0x3C then 0xF0, one pulse each.
- Prescale=32, PAR_EN=1, PAR_TYP=1 (odd), frame 0x55 with parity bit 1 -> P_DATA=0x55, data_valid pulses.
- PAR_EN=1, PAR_TYP=0 (even), frame 0xAA with parity bit 0 -> P_DATA=0xAA. Repeat with parity bit 1 -> no data_valid, P_DATA stays 0xAA.
- Stop bit driven 0 on frame 0x12 -> no data_valid, P_DATA unchanged. A following good frame 0x34 -> P_DATA=0x34.
- Low glitch of P/4 cycles on idle line -> no strobe, FSM back in IDLE. Asserting RST during a data bit -> P_DATA=0x00, data_valid=0; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, 8 data LSB-first, opt parity, stop).
// CLK/RST, RX_IN line, Prescale/PAR_EN/PAR_TYP config; P_DATA + data_valid out.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid
);
  localparam int PW = PRESCALE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] TWO      = PW'(2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] p_reg;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          par_en_r;
  logic          par_typ_r;
  logic          par_err;
  logic          stp_err;
  logic [2:0]    smp;
  logic [DW-1:0] data_sr;

  logic [PW-1:0] half;
  logic          last_edge;
  logic          decide;
  logic          maj;
  logic          par_exp;

  always_comb begin
    half      = p_reg >> 1;
    last_edge = (edge_cnt == p_reg - ONE);
    decide    = (edge_cnt == half + TWO);
    maj       = (smp[0] & smp[1]) |
                (smp[0] & smp[2]) |
                (smp[1] & smp[2]);
    par_exp   = (^data_sr) ^ par_typ_r;
  end

  // The detection cycle in IDLE is edge 0 of the start bit, so the
  // counter leaves IDLE already at 1 and a frame is exactly
  // (10 + PAR_EN) * P cycles long.  edge_cnt wraps naturally, so
  // even an illegal Prescale always reaches last_edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      p_reg      <= '0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      smp        <= '0;
      data_sr    <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state != IDLE) begin
        edge_cnt <= last_edge ? '0 : edge_cnt + ONE;
        if (edge_cnt == half - ONE) smp[0] <= RX_IN;
        if (edge_cnt == half)       smp[1] <= RX_IN;
        if (edge_cnt == half + ONE) smp[2] <= RX_IN;
      end
      unique case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            edge_cnt  <= ONE;
            p_reg     <= Prescale;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (decide && maj) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (last_edge) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) data_sr[bit_cnt] <= maj;
          if (last_edge) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (decide && (maj != par_exp)) par_err <= 1'b1;
          if (last_edge) state <= STOP;
        end
        STOP: begin
          if (decide && !maj) stp_err <= 1'b1;
          if (last_edge) begin
            state <= IDLE;
            if (!par_err && !stp_err) begin
              P_DATA     <= data_sr;
              data_valid <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Frames are built from bytes; a queue model predicts accepted bytes.
`timescale 1ns/1ps
module tb_uart_rx;
  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_good;

  uart_rx dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // every strobe cycle records one byte; a stretched strobe shows
  // up as an extra entry
  always @(negedge CLK)
    if (data_valid === 1'b1) got_q.push_back(P_DATA);

  initial begin
    #3ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic par_bit(input logic [7:0] d,
                                   input logic typ);
    logic odd;
    odd = ($countones(d) % 2) != 0;
    return odd ^ typ;
  endfunction

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p,
                            input logic pen, input logic ptyp,
                            input logic pbad, input logic sbad,
                            input logic scr);
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    send_bit(1'b0, p);
    if (scr) begin
      Prescale = 6'(8 << $urandom_range(0, 2));
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit(par_bit(d, ptyp) ^ pbad, p);
    send_bit(~sbad, p);
    if (!sbad && !(pen && pbad)) begin
      exp_q.push_back(d);
      last_good = d;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge CLK);
    total++;
    if (P_DATA !== 8'h00) begin
      bad++;
      $display("FAIL reset_pdata got=%h exp=00", P_DATA);
    end
    total++;
    if (data_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0", data_valid);
    end
    RST = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    exp_q.delete(); got_q.delete();
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0);
    idle(40);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL basic_count got=%0d exp=1", got_q.size());
    end
    total++;
    if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin
      bad++;
      $display("FAIL basic_data got=%h exp=a5", got_q[0]);
    end
    total++;
    if (P_DATA !== last_good) begin
      bad++;
      $display("FAIL basic_hold got=%h exp=%h", P_DATA, last_good);
    end
  endtask

  task automatic test_prescale();
    exp_q.delete(); got_q.delete();
    send_frame(8'h3C, 16, 0, 0, 0, 0, 0);
    idle(4);
    total++;
    if (P_DATA !== 8'h3C) begin
      bad++;
      $display("FAIL p16_data got=%h exp=3c", P_DATA);
    end
    send_frame(8'hF0, 32, 0, 0, 0, 0, 0);
    idle(4);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL p32_count got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    total++;
    if (P_DATA !== last_good) begin
      bad++;
      $display("FAIL p32_data got=%h exp=%h", P_DATA, last_good);
    end
  endtask

  task automatic test_parity();
    exp_q.delete(); got_q.delete();
    send_frame(8'h55, 32, 1, 1, 0, 0, 0);
    idle(4);
    total++;
    if (P_DATA !== 8'h55) begin
      bad++;
      $display("FAIL par_odd got=%h exp=55", P_DATA);
    end
    send_frame(8'hAA, 8, 1, 0, 0, 0, 0);
    idle(4);
    total++;
    if (P_DATA !== 8'hAA) begin
      bad++;
      $display("FAIL par_even got=%h exp=aa", P_DATA);
    end
    send_frame(8'hAA, 8, 1, 0, 1, 0, 0);
    idle(4);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL par_err_count got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    total++;
    if (P_DATA !== last_good) begin
      bad++;
      $display("FAIL par_err_hold got=%h exp=%h", P_DATA, last_good);
    end
  endtask

  task automatic test_stop_err();
    exp_q.delete(); got_q.delete();
    send_frame(8'h12, 16, 0, 0, 0, 1, 0);
    idle(6);
    total++;
    if (got_q.size() != 0 || P_DATA !== last_good) begin
      bad++;
      $display("FAIL stop_err got=%0d/%h exp=0/%h",
               got_q.size(), P_DATA, last_good);
    end
    send_frame(8'h34, 16, 0, 0, 0, 0, 0);
    idle(4);
    total++;
    if (got_q.size() != 1 || P_DATA !== 8'h34) begin
      bad++;
      $display("FAIL stop_recover got=%0d/%h exp=1/34",
               got_q.size(), P_DATA);
    end
  endtask

  task automatic test_glitch();
    exp_q.delete(); got_q.delete();
    Prescale = 6'd16;
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    idle(40);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_strobe got=%0d exp=0", got_q.size());
    end
    send_frame(8'h3B, 16, 0, 0, 0, 0, 0);
    idle(4);
    total++;
    if (got_q.size() != 1 || P_DATA !== 8'h3B) begin
      bad++;
      $display("FAIL glitch_after got=%0d/%h exp=1/3b",
               got_q.size(), P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); got_q.delete();
    send_frame(8'h5A, 8, 0, 0, 0, 0, 0);
    send_frame(8'hC3, 8, 1, 1, 0, 0, 0);
    send_frame(8'h81, 8, 0, 0, 0, 0, 0);
    idle(4);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_data[%0d] got=%h exp=%h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); got_q.delete();
    Prescale = 6'd16; PAR_EN = 1'b0;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);
    #3 RST = 1'b0;
    #1;
    last_good = 8'h00;
    total++;
    if (P_DATA !== 8'h00 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%h/%b exp=00/0",
               P_DATA, data_valid);
    end
    @(negedge CLK);
    idle(3);
    RST = 1'b1;
    idle(5);
    send_frame(8'hC6, 16, 0, 0, 0, 0, 0);
    idle(4);
    total++;
    if (got_q.size() != 1 || P_DATA !== 8'hC6) begin
      bad++;
      $display("FAIL rst_recover got=%0d/%h exp=1/c6",
               got_q.size(), P_DATA);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int p;
    exp_q.delete(); got_q.delete();
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = 8 << $urandom_range(0, 2);
      send_frame(d, p, 1'($urandom), 1'($urandom),
                 ($urandom % 5) == 0, ($urandom % 6) == 0,
                 1'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(4);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_data[%0d] got=%h exp=%h",
                 i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (P_DATA !== last_good) begin
      bad++;
      $display("FAIL rand_hold got=%h exp=%h", P_DATA, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
